// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM address and
// hands the fetched word to the F/D latch, squashing wrong-path fetches to NOP.
//
// state    | meaning
// UNPRIMED | first cycle after reset; ROM output is stale, PC holds
// PRIMED   | ROM output valid for the current pc; normal fetch
module fetch_stage #(
  parameter int                  PC_WIDTH   = 12,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirectPc,
  output logic [PC_WIDTH-1:0]   imemAddr,
  input  logic [INST_WIDTH-1:0] imemData,
  output logic [INST_WIDTH-1:0] instOut,
  output logic [PC_WIDTH-1:0]   seqNextPcOut,
  output logic                  fetchEnable,
  output logic                  flushOut,
  output logic [PC_WIDTH-1:0]   pcOut,
  output logic [CNT_WIDTH-1:0]  fetchCount
);

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } fetchState_t;

  fetchState_t          state;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  pcInc;
  logic [PC_WIDTH-1:0]  pcNext;
  logic                 primed;
  logic                 countEnable;

  assign primed = (state == PRIMED);
  assign pcInc  = pc + PC_ONE;

  // The priming cycle holds pc so the ROM captures RESET_PC and the first
  // valid word out is the one at RESET_PC rather than RESET_PC+1.
  always_comb begin
    pcNext = pcInc;
    if (redirect) begin
      pcNext = redirectPc;
    end else if (stall || !primed) begin
      pcNext = pc;
    end
  end

  assign imemAddr     = pcNext;
  assign pcOut        = pc;
  assign seqNextPcOut = pcInc;
  assign instOut      = (!primed || redirect || reset) ? '0 : imemData;
  assign fetchEnable  = primed & (~stall | redirect);
  assign flushOut     = redirect & ~reset;
  assign countEnable  = fetchEnable & ~redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= UNPRIMED;
      pc         <= RESET_PC;
      fetchCount <= '0;
    end else begin
      pc <= pcNext;
      case (state)
        UNPRIMED: state <= PRIMED;
        PRIMED:   state <= PRIMED;
        default:  state <= UNPRIMED;
      endcase
      if (countEnable) begin
        fetchCount <= fetchCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a hand-written
// asynchronous mid-cycle reset sequence. ROM model holds 0x1000_0000 + address.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [11:0] redirectPc;
  logic [11:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instOut;
  logic [11:0] seqNextPcOut;
  logic        fetchEnable;
  logic        flushOut;
  logic [11:0] pcOut;
  logic [15:0] fetchCount;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .PC_WIDTH(12), .INST_WIDTH(32), .RESET_PC(12'h000), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemAddr(imemAddr), .imemData(imemData),
    .instOut(instOut), .seqNextPcOut(seqNextPcOut), .fetchEnable(fetchEnable),
    .flushOut(flushOut), .pcOut(pcOut), .fetchCount(fetchCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  always @(posedge clock) imemData <= rom(imemAddr);

  typedef struct {
    logic        rst, st, rd;
    logic [11:0] rpc, pc, addr, seq;
    logic [31:0] inst;
    logic        fe, fl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic rst, st, rd, input logic [11:0] rpc,
                              input logic [11:0] pc, addr, seq,
                              input logic [31:0] inst, input logic fe, fl,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc;
    v.pc = pc; v.addr = addr; v.seq = seq; v.inst = inst;
    v.fe = fe; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    check({tag, " pcOut"},        {20'h0, pcOut},        {20'h0, v.pc});
    check({tag, " imemAddr"},     {20'h0, imemAddr},     {20'h0, v.addr});
    check({tag, " seqNextPcOut"}, {20'h0, seqNextPcOut}, {20'h0, v.seq});
    check({tag, " instOut"},      instOut,               v.inst);
    check({tag, " fetchEnable"},  {31'h0, fetchEnable},  {31'h0, v.fe});
    check({tag, " flushOut"},     {31'h0, flushOut},     {31'h0, v.fl});
    check({tag, " fetchCount"},   {16'h0, fetchCount},   {16'h0, v.cnt});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;

    //                rst st rd rpc     pc      addr    seq     inst          fe fl cnt
    vecs[0]  = mk(1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h001, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h001, 32'h0,        0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 12'h000, 12'h000, 12'h000, 12'h001, 32'h0,        0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 12'h000, 12'h000, 12'h001, 12'h001, rom(12'h000), 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 12'h000, 12'h001, 12'h002, 12'h002, rom(12'h001), 1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 12'h000, 12'h002, 12'h003, 12'h003, rom(12'h002), 1, 0, 2);
    vecs[6]  = mk(0, 0, 0, 12'h000, 12'h003, 12'h004, 12'h004, rom(12'h003), 1, 0, 3);
    vecs[7]  = mk(0, 0, 0, 12'h000, 12'h004, 12'h005, 12'h005, rom(12'h004), 1, 0, 4);
    vecs[8]  = mk(0, 1, 0, 12'h000, 12'h005, 12'h005, 12'h006, rom(12'h005), 0, 0, 5);
    vecs[9]  = mk(0, 1, 0, 12'h000, 12'h005, 12'h005, 12'h006, rom(12'h005), 0, 0, 5);
    vecs[10] = mk(0, 1, 0, 12'h000, 12'h005, 12'h005, 12'h006, rom(12'h005), 0, 0, 5);
    vecs[11] = mk(0, 0, 0, 12'h000, 12'h005, 12'h006, 12'h006, rom(12'h005), 1, 0, 5);
    vecs[12] = mk(0, 0, 0, 12'h000, 12'h006, 12'h007, 12'h007, rom(12'h006), 1, 0, 6);
    vecs[13] = mk(0, 0, 1, 12'h020, 12'h007, 12'h020, 12'h008, 32'h0,        1, 1, 7);
    vecs[14] = mk(0, 0, 0, 12'h000, 12'h020, 12'h021, 12'h021, rom(12'h020), 1, 0, 7);
    vecs[15] = mk(0, 0, 1, 12'h009, 12'h021, 12'h009, 12'h022, 32'h0,        1, 1, 8);
    vecs[16] = mk(0, 1, 1, 12'h100, 12'h009, 12'h100, 12'h00A, 32'h0,        1, 1, 8);
    vecs[17] = mk(0, 0, 0, 12'h000, 12'h100, 12'h101, 12'h101, rom(12'h100), 1, 0, 8);
    vecs[18] = mk(0, 0, 1, 12'hFFF, 12'h101, 12'hFFF, 12'h102, 32'h0,        1, 1, 9);
    vecs[19] = mk(0, 0, 0, 12'h000, 12'hFFF, 12'h000, 12'h000, rom(12'hFFF), 1, 0, 9);
    vecs[20] = mk(0, 0, 0, 12'h000, 12'h000, 12'h001, 12'h001, rom(12'h000), 1, 0, 10);
    vecs[21] = mk(0, 0, 0, 12'h000, 12'h001, 12'h002, 12'h002, rom(12'h001), 1, 0, 11);
    vecs[22] = mk(0, 0, 1, 12'h002, 12'h002, 12'h002, 12'h003, 32'h0,        1, 1, 12);
    vecs[23] = mk(0, 0, 0, 12'h000, 12'h002, 12'h003, 12'h003, rom(12'h002), 1, 0, 12);
    vecs[24] = mk(0, 0, 1, 12'h040, 12'h003, 12'h040, 12'h004, 32'h0,        1, 1, 13);
    vecs[25] = mk(0, 0, 1, 12'h050, 12'h040, 12'h050, 12'h041, 32'h0,        1, 1, 13);
    vecs[26] = mk(0, 0, 0, 12'h000, 12'h050, 12'h051, 12'h051, rom(12'h050), 1, 0, 13);
    vecs[27] = mk(0, 0, 1, 12'h030, 12'h051, 12'h030, 12'h052, 32'h0,        1, 1, 14);
    vecs[28] = mk(0, 0, 0, 12'h000, 12'h030, 12'h031, 12'h031, rom(12'h030), 1, 0, 14);

    for (int i = 0; i < 29; i++) begin
      @(negedge clock);
      reset = vecs[i].rst; stall = vecs[i].st;
      redirect = vecs[i].rd; redirectPc = vecs[i].rpc;
      #1;
      checkRow($sformatf("row%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-cycle at pc=0x030, with a redirect pending.
    #1;
    reset = 1'b1; redirect = 1'b1; redirectPc = 12'h0AB;
    #1;
    check("async pcOut",       {20'h0, pcOut},       32'h0);
    check("async instOut",     instOut,              32'h0);
    check("async fetchEnable", {31'h0, fetchEnable}, 32'h0);
    check("async flushOut",    {31'h0, flushOut},    32'h0);
    check("async fetchCount",  {16'h0, fetchCount},  32'h0);

    @(negedge clock);
    redirect = 1'b0; redirectPc = '0;
    #1;
    check("held pcOut",        {20'h0, pcOut},       32'h0);
    check("held fetchEnable",  {31'h0, fetchEnable}, 32'h0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reprime instOut",     instOut,              32'h0);
    check("reprime fetchEnable", {31'h0, fetchEnable}, 32'h0);
    check("reprime imemAddr",    {20'h0, imemAddr},    32'h0);

    @(negedge clock);
    #1;
    check("first pcOut",        {20'h0, pcOut},        32'h0);
    check("first instOut",      instOut,               rom(12'h000));
    check("first seqNextPcOut", {20'h0, seqNextPcOut}, 32'h1);
    check("first fetchEnable",  {31'h0, fetchEnable},  32'h1);

    @(negedge clock);
    #1;
    check("second pcOut",      {20'h0, pcOut},      32'h1);
    check("second instOut",    instOut,             rom(12'h001));
    check("second fetchCount", {16'h0, fetchCount}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
